uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 135 +++++++++++++
 tb/tb_uart_rx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with start-glitch rejection and a held-low BREAK state.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling centred in each bit.
module uart_rx #(
    parameter int CLKS_PER_BIT = 521
) (
    input  logic       clk_uart_i,
    input  logic       rst_n,
    input  logic       rx_serial_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_dv_o,
    output logic       rx_active_o,
    output logic       rx_frame_err_o
);
    localparam int CW    = $clog2(CLKS_PER_BIT) + 1;
    localparam int MID_I = (CLKS_PER_BIT - 1) / 2;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID  = CW'(MID_I);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state;
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          rxs, at_last, start_at, start_s, start_end, bit_s;

    assign rxs     = sync[1];
    assign at_last = cnt == LAST;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0] MID_LO  = CW'(MID_I - 1);
    localparam logic [CW-1:0] MID_HI  = CW'(MID_I + 1);
    localparam logic [CW-1:0] PRE_END = CW'(CLKS_PER_BIT - 2);

    logic [2:0] votes;

    function automatic logic maj(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // The start bit runs one cycle short so data bits begin on a bit boundary
    // and counter MID lands in the middle of every data and stop bit.
    assign start_at  = cnt == MID_HI;
    assign start_s   = maj(votes[1], votes[0], rxs);
    assign start_end = cnt == PRE_END;
    assign bit_s     = maj(votes[2], votes[1], votes[0]);

    always_ff @(posedge clk_uart_i or negedge rst_n) begin
        if (!rst_n)
            votes <= '0;
        else if (cnt >= MID_LO && cnt <= MID_HI)
            votes <= {votes[1:0], rxs};
    end
`else
    assign start_at  = cnt == MID;
    assign start_s   = rxs;
    assign start_end = start_at;
    assign bit_s     = rxs;
`endif

    always_ff @(posedge clk_uart_i or negedge rst_n) begin
        if (!rst_n) begin
            sync           <= 2'b11;
            state          <= IDLE;
            cnt            <= '0;
            idx            <= '0;
            shreg          <= '0;
            rx_byte_o      <= '0;
            rx_dv_o        <= 1'b0;
            rx_active_o    <= 1'b0;
            rx_frame_err_o <= 1'b0;
        end else begin
            sync           <= {sync[0], rx_serial_i};
            rx_dv_o        <= 1'b0;
            rx_frame_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    cnt         <= '0;
                    idx         <= '0;
                    rx_active_o <= 1'b0;
                    if (!rxs)
                        state <= START;
                end
                START: begin
                    if (start_at && start_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (start_end) begin
                        state       <= DATA;
                        cnt         <= '0;
                        rx_active_o <= 1'b1;
                    end else
                        cnt <= cnt + 1'b1;
                end
                DATA: begin
                    if (at_last) begin
                        shreg[idx] <= bit_s;
                        cnt        <= '0;
                        idx        <= idx + 1'b1;
                        if (idx == 3'd7)
                            state <= STOP;
                    end else
                        cnt <= cnt + 1'b1;
                end
                STOP: begin
                    if (at_last) begin
                        cnt         <= '0;
                        rx_active_o <= 1'b0;
                        if (bit_s) begin
                            rx_byte_o <= shreg;
                            rx_dv_o   <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            rx_frame_err_o <= 1'b1;
                            state          <= BREAK;
                        end
                    end else
                        cnt <= cnt + 1'b1;
                end
                BREAK: begin
                    rx_active_o <= 1'b0;
                    if (rxs)
                        state <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    cnt         <= '0;
                    idx         <= '0;
                    rx_active_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random 8N1 frames against a byte-level reference model.
module tb_uart_rx;
    localparam int C   = 8;
    localparam int C16 = 16;
    localparam int MID = (C - 1) / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT_LO = 9 * C + MID + 2;
    localparam int LAT_HI = 10 * C + 3;
    localparam int GLITCH_OFF = (C16 - 1) / 2;
    localparam logic [7:0] EXP_GLITCH = 8'h00;
`else
    localparam int LAT_LO = 9 * C + MID + 2;
    localparam int LAT_HI = 9 * C + MID + 4;
    localparam int GLITCH_OFF = (C16 - 1) / 2 + 1;
    localparam logic [7:0] EXP_GLITCH = 8'h08;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx8 = 1'b1;
    logic       rx16 = 1'b1;
    logic [7:0] byte8, byte16;
    logic       dv8, act8, err8, dv16, act16, err16;

    int vectors = 0;
    int miscompares = 0;

    int cyc = 0, dv_cnt = 0, err_cnt = 0, dv16_cnt = 0, both_cnt = 0, act_bad = 0;
    int last_cyc = 0, prev_cyc = 0;
    logic [7:0] last_b = 8'h00, prev_b = 8'h00;
    logic act_prev = 1'b0;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk_uart_i(clk), .rst_n(rst_n), .rx_serial_i(rx8),
        .rx_byte_o(byte8), .rx_dv_o(dv8), .rx_active_o(act8), .rx_frame_err_o(err8)
    );

    uart_rx #(.CLKS_PER_BIT(C16)) dut16 (
        .clk_uart_i(clk), .rst_n(rst_n), .rx_serial_i(rx16),
        .rx_byte_o(byte16), .rx_dv_o(dv16), .rx_active_o(act16), .rx_frame_err_o(err16)
    );

    // Event recorder: pulse counts, captured bytes, and pulse/active invariants.
    always @(negedge clk) begin
        cyc      <= cyc + 1;
        act_prev <= act8;
        if (dv8) begin
            dv_cnt   <= dv_cnt + 1;
            last_b   <= byte8;
            prev_b   <= last_b;
            last_cyc <= cyc;
            prev_cyc <= last_cyc;
        end
        if (err8)
            err_cnt <= err_cnt + 1;
        if (dv16)
            dv16_cnt <= dv16_cnt + 1;
        if (dv8 && err8)
            both_cnt <= both_cnt + 1;
        if ((dv8 || err8) && (act8 || !act_prev))
            act_bad <= act_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives ncyc cycles of an LSB-first 8N1 frame; one cycle may be inverted.
    task automatic frame(input int which, input logic [7:0] b, input logic stop,
                         input int ncyc, input int glitch);
        logic [9:0] bits;
        int cpb;
        bits = {stop, b, 1'b0};
        cpb  = which != 0 ? C16 : C;
        for (int c = 0; c < ncyc; c++) begin
            if (which != 0)
                rx16 = bits[c / cpb] ^ (c == glitch);
            else
                rx8 = bits[c / cpb] ^ (c == glitch);
            @(negedge clk);
        end
    endtask

    task automatic idle8(input int n);
        rx8 = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int t0, d0, e0, lat, exp_dv, exp_err;
        logic [7:0] exp_b, b;
        logic ok, any_act;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_byte", byte8, 0);
        check("rst_flags", {dv8, act8, err8}, 0);
        check("rst_dut16", {byte16, dv16, act16, err16}, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        t0 = cyc;
        frame(0, 8'hA5, 1'b1, 10 * C, -1);
        idle8(3 * C);
        check("a5_dv_count", dv_cnt, 1);
        check("a5_pulse_byte", last_b, 8'hA5);
        check("a5_byte_hold", byte8, 8'hA5);
        check("a5_err_count", err_cnt, 0);
        lat = last_cyc - t0;
        vectors++;
        assert (lat >= LAT_LO && lat <= LAT_HI) else begin
            miscompares++;
            $error("FAIL a5_latency: observed %0d expected %0d..%0d", lat, LAT_LO, LAT_HI);
        end

        d0 = dv_cnt;
        e0 = err_cnt;
        any_act = 1'b0;
        for (int i = 0; i < 3 * C + 2; i++) begin
            rx8 = i < 2 ? 1'b0 : 1'b1;
            @(negedge clk);
            any_act |= act8;
        end
        check("glitch_dv", dv_cnt, d0);
        check("glitch_err", err_cnt, e0);
        check("glitch_active", any_act, 0);

        frame(0, 8'h3C, 1'b0, 10 * C, -1);
        any_act = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rx8 = 1'b0;
            @(negedge clk);
            if (i >= C / 2)
                any_act |= act8;
        end
        check("ferr_count", err_cnt, e0 + 1);
        check("ferr_no_dv", dv_cnt, d0);
        check("ferr_byte_kept", byte8, 8'hA5);
        check("ferr_break_active", any_act, 0);
        idle8(2 * C);
        check("ferr_no_retrigger", err_cnt, e0 + 1);

        d0 = dv_cnt;
        frame(0, 8'h00, 1'b1, 10 * C, -1);
        frame(0, 8'hFF, 1'b1, 10 * C, -1);
        idle8(3 * C);
        check("b2b_dv_count", dv_cnt, d0 + 2);
        check("b2b_first", prev_b, 8'h00);
        check("b2b_second", last_b, 8'hFF);
        check("b2b_spacing", last_cyc - prev_cyc, 10 * C);

        d0 = dv_cnt;
        e0 = err_cnt;
        frame(0, 8'h12, 1'b1, 5 * C + C / 2, -1);
        rst_n = 1'b0;
        rx8 = 1'b1;
        @(negedge clk);
        check("midrst_byte", byte8, 0);
        check("midrst_flags", {dv8, act8, err8}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle8(2 * C);
        frame(0, 8'h5A, 1'b1, 10 * C, -1);
        idle8(3 * C);
        check("midrst_dv_count", dv_cnt, d0 + 1);
        check("midrst_byte_5a", last_b, 8'h5A);
        check("midrst_err", err_cnt, e0);

        exp_dv  = dv_cnt;
        exp_err = err_cnt;
        exp_b   = 8'h5A;
        for (int n = 0; n < 24; n++) begin
            b  = 8'($urandom_range(0, 255));
            ok = $urandom_range(0, 4) != 0;
            frame(0, b, ok, 10 * C, -1);
            if (!ok) begin
                rx8 = 1'b0;
                repeat ($urandom_range(0, 12)) @(negedge clk);
            end
            idle8($urandom_range(3, 2 * C));
            if (ok) begin
                exp_dv++;
                exp_b = b;
            end else
                exp_err++;
            check("rnd_dv_count", dv_cnt, exp_dv);
            check("rnd_err_count", err_cnt, exp_err);
            check("rnd_byte", byte8, exp_b);
        end

        frame(1, 8'h00, 1'b1, 10 * C16, 4 * C16 + GLITCH_OFF);
        rx16 = 1'b1;
        repeat (3 * C16) @(negedge clk);
        check("c16_dv_count", dv16_cnt, 1);
        check("c16_glitch_byte", byte16, EXP_GLITCH);

        check("dv_err_overlap", both_cnt, 0);
        check("active_fall_align", act_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
